// File: rtl/out_port_uart_tx.sv
// Serial console stage for the CPU out-port: new Output_Data values are queued
// in a word FIFO and each word is sent as four 8N1 frames, low byte first.
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [31:0]                   Output_Data,
    input  logic                          Run,
    output logic                          Tx,
    output logic                          Busy,
    output logic                          Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Depth
);

    localparam int DATA_W = 32;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BW     = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and change detector
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] prev_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ovf_q, ovf_d;

    // Transmitter state
    logic [1:0]        state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              empty;
    logic              full;
    logic              baud_end;
    logic [4:0]        tx_idx;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign baud_end = (baud_q == BAUD_LAST);
    assign push_req = Run && (Output_Data != prev_q);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - (AW + 1)'(1);
        end
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        tx_idx  = {byte_q, bit_q};
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    byte_d  = 2'd0;
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_idx  = {byte_q, 3'd0};
                    tx_d    = shift_q[tx_idx];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tx_idx = {byte_q, bit_q + 3'd1};
                        tx_d   = shift_q[tx_idx];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else if (!empty) begin
                        // Back-to-back words: next start bit follows this stop bit directly.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        byte_d  = 2'd0;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            prev_q   <= Output_Data;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push_ok && !Reset) begin
            mem_q[wr_ptr_q] <= Output_Data;
        end
        shift_q <= shift_d;
    end

    assign Tx       = tx_q;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;
    assign Depth    = count_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: directed scenarios plus random traffic, every
// cycle compared against a queue-based model of the serial line.
module tb_out_port_uart_tx;

    localparam int CPB    = 4;
    localparam int DEPTH  = 4;
    localparam int WORD_T = 40 * CPB;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Output_Data;
    logic        Run;
    logic        Tx;
    logic        Busy;
    logic        Overflow;
    logic [2:0]  Depth;

    always #5 Clock = ~Clock;

    out_port_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Output_Data(Output_Data),
        .Run        (Run),
        .Tx         (Tx),
        .Busy       (Busy),
        .Overflow   (Overflow),
        .Depth      (Depth)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: word queue, the word on the line and when it started
    logic [31:0] m_q[$];
    logic [31:0] m_prev;
    logic [31:0] m_cur;
    bit          m_active;
    bit          m_ovf;
    int          m_start;
    int          ecnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, ecnt);
    endtask

    function automatic logic exp_tx();
        int o, f, b;
        if (!m_active) return 1'b1;
        o = ecnt - m_start;
        f = o / (10 * CPB);
        b = (o % (10 * CPB)) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[8 * f + b - 1];
    endfunction

    task automatic model_edge();
        int  sz0;
        bit  pop, push;
        ecnt++;
        if (Reset) begin
            m_q.delete();
            m_prev   = '0;
            m_active = 0;
            m_ovf    = 0;
            return;
        end
        if (m_active && (ecnt - m_start >= WORD_T)) m_active = 0;
        sz0  = m_q.size();
        pop  = (sz0 > 0) && !m_active;
        push = Run && (Output_Data != m_prev);
        if (pop) begin
            m_cur    = m_q.pop_front();
            m_start  = ecnt;
            m_active = 1;
        end
        if (push) begin
            if (sz0 < DEPTH || pop) m_q.push_back(Output_Data);
            else m_ovf = 1;
        end
        m_prev = Output_Data;
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
        chk("tx", 32'(Tx), 32'(exp_tx()));
        chk("busy", 32'(Busy), 32'(m_active));
        chk("depth", 32'(Depth), 32'(m_q.size()));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
    endtask

    initial begin
        int rise, fall, starts;
        bit prevb, low_seen;

        Reset = 1'b1;
        Run = 1'b0;
        Output_Data = '0;
        repeat (3) step();

        // Single word after reset: line timing and busy length
        Reset = 1'b0;
        Run = 1'b1;
        Output_Data = 32'h12345678;
        rise = -1;
        fall = -1;
        for (int i = 0; i < 170; i++) begin
            step();
            if (Busy && rise < 0) rise = ecnt;
            if (!Busy && rise >= 0 && fall < 0) fall = ecnt;
        end
        chk("busy_len", 32'(fall - rise), 32'd160);

        // Held value produces one word
        Output_Data = 32'hA5A5A5A5;
        starts = 0;
        prevb = Busy;
        for (int i = 0; i < 500; i++) begin
            step();
            if (Busy && !prevb) starts++;
            prevb = Busy;
        end
        chk("one_word", 32'(starts), 32'd1);
        chk("held_depth0", 32'(Depth), 32'd0);

        // Run low: changes never reach the line
        Run = 1'b0;
        low_seen = 0;
        for (int i = 0; i < 60; i++) begin
            Output_Data = (i % 2 == 0) ? 32'h1 : 32'h2;
            step();
            if (!Tx || Depth != 3'd0) low_seen = 1;
        end
        chk("run0_quiet", 32'(low_seen), 32'd0);

        // Six values back to back: one on the line, four queued, one dropped
        Run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Output_Data = 32'hC0DE0001 + 32'(i) * 32'h01010101;
            step();
        end
        chk("burst_depth", 32'(Depth), 32'd4);
        chk("burst_ovf", 32'(Overflow), 32'd1);
        repeat (5 * WORD_T + 40) step();
        chk("ovf_sticky", 32'(Overflow), 32'd1);

        // Full FIFO with a pop and a fresh change on the same edge
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Output_Data = 32'h3C000000 + 32'(i) * 32'h00110077;
            step();
        end
        for (int i = 0; i < 400 && (ecnt + 1 != m_start + WORD_T); i++) step();
        Output_Data = 32'h77777777;
        step();
        chk("full_pp_depth", 32'(Depth), 32'd4);
        chk("full_pp_ovf", 32'(Overflow), 32'd0);
        repeat (5 * WORD_T + 40) step();

        // Reset in the middle of byte 2's data bits
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Output_Data = 32'h0BADF00D;
        for (int i = 0; i < 300 && !(m_active && (ecnt - m_start == 23 * CPB)); i++) step();
        Reset = 1'b1;
        step();
        chk("rst_tx", 32'(Tx), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_depth", 32'(Depth), 32'd0);
        Reset = 1'b0;
        Output_Data = 32'h5EED1234;
        repeat (200) step();

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            Reset = ($urandom_range(0, 299) == 0);
            Run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) Output_Data = $urandom;
            else if ($urandom_range(0, 399) == 0) Output_Data = Output_Data + 32'd1;
            step();
        end
        Reset = 1'b0;
        repeat (6 * WORD_T) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
